// File: rtl/tdsp_ds_dma_wr_if.sv
`default_nettype none
// ============================================================================
// Module : tdsp_ds_dma_wr_if
// Desc   : Data-bus side of the TDSP sample DMA writer (request/grant, write).
// Rev    : 1.0
// ============================================================================
interface tdsp_ds_dma_wr_if #(
    parameter int DATA_W  = 16,
    parameter int HALF_AW = 7
) ();
    logic                bus_request;
    logic                bus_grant;
    logic                as;
    logic                write;
    logic [HALF_AW:0]    address;
    logic [DATA_W-1:0]   data_out;
    logic                top_buf_flag;

    modport master (
        output bus_request, as, write, address, data_out, top_buf_flag,
        input  bus_grant
    );

    modport slave (
        input  bus_request, as, write, address, data_out, top_buf_flag,
        output bus_grant
    );
endinterface
`default_nettype wire

// File: rtl/tdsp_ds_dma_wr.sv
`default_nettype none
// ============================================================================
// Module : tdsp_ds_dma_wr
// Desc   : Single-entry DMA writer filling the ping-pong TDSP sample memory.
// Rev    : 1.0
// ============================================================================
module tdsp_ds_dma_wr #(
    parameter int DATA_W  = 16,
    parameter int HALF_AW = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dma_enable,
    input  logic                sample_valid,
    input  logic [DATA_W-1:0]   sample_data,
    input  logic                clr_overrun,
    output logic                half_done,
    output logic                overrun,
    tdsp_ds_dma_wr_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_XFER    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic                  r_hold_valid;
    logic [DATA_W-1:0]     r_hold_data;
    logic [HALF_AW-1:0]    r_wr_count;
    logic                  r_top_buf_flag;
    logic                  r_half_done;
    logic                  r_overrun;
    logic                  r_bus_request;
    logic                  r_as;
    logic [HALF_AW:0]      r_address;
    logic [DATA_W-1:0]     r_data_out;

    logic                  w_accept;
    logic                  w_hold_free;
    logic                  w_capture;
    logic                  w_drop;
    logic                  w_wrap;
    logic                  w_req_nxt;
    logic                  w_as_nxt;
    logic [HALF_AW:0]      w_addr_nxt;
    logic [DATA_W-1:0]     w_data_nxt;

    // The holding entry is consumed during XFER, so that cycle may refill it.
    assign w_accept    = sample_valid & dma_enable;
    assign w_hold_free = ~r_hold_valid | (r_state == S_XFER);
    assign w_capture   = w_accept & w_hold_free;
    assign w_drop      = w_accept & ~w_hold_free;
    assign w_wrap      = (r_state == S_XFER) && (r_wr_count == {HALF_AW{1'b1}});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs are registered from the next state, so they line up with it.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (r_hold_valid || w_capture) w_next_state = S_REQ;
            S_REQ:     if (bus.bus_grant) w_next_state = S_XFER;
            S_XFER:    w_next_state = S_RELEASE;
            S_RELEASE: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
        w_req_nxt  = (w_next_state == S_REQ) || (w_next_state == S_XFER);
        w_as_nxt   = (w_next_state == S_XFER);
        w_addr_nxt = w_as_nxt ? {r_top_buf_flag, r_wr_count} : '0;
        w_data_nxt = w_as_nxt ? r_hold_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold_valid   <= 1'b0;
            r_hold_data    <= '0;
            r_wr_count     <= '0;
            r_top_buf_flag <= 1'b0;
            r_half_done    <= 1'b0;
            r_overrun      <= 1'b0;
            r_bus_request  <= 1'b0;
            r_as           <= 1'b0;
            r_address      <= '0;
            r_data_out     <= '0;
        end else begin
            if (w_capture) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= sample_data;
            end else if (r_state == S_XFER) begin
                r_hold_valid <= 1'b0;
            end

            if (r_state == S_XFER) begin
                r_wr_count <= r_wr_count + 1'b1;
                if (w_wrap) begin
                    r_top_buf_flag <= ~r_top_buf_flag;
                end
            end
            r_half_done <= w_wrap;

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end

            r_bus_request <= w_req_nxt;
            r_as          <= w_as_nxt;
            r_address     <= w_addr_nxt;
            r_data_out    <= w_data_nxt;
        end
    end

    assign bus.bus_request  = r_bus_request;
    assign bus.as           = r_as;
    assign bus.write        = r_as;
    assign bus.address      = r_address;
    assign bus.data_out     = r_data_out;
    assign bus.top_buf_flag = r_top_buf_flag;
    assign half_done        = r_half_done;
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_tdsp_ds_dma_wr.sv
`default_nettype none
// ============================================================================
// Module : tb_tdsp_ds_dma_wr
// Desc   : Self-checking bench for the TDSP sample DMA writer.
// Rev    : 1.0
// ============================================================================
module tb_tdsp_ds_dma_wr;
    localparam int DATA_W  = 16;
    localparam int HALF_AW = 7;

    logic              clk          = 1'b0;
    logic              reset        = 1'b0;
    logic              dma_enable   = 1'b0;
    logic              sample_valid = 1'b0;
    logic              clr_overrun  = 1'b0;
    logic              grant        = 1'b0;
    logic [DATA_W-1:0] sample_data  = '0;
    logic              half_done;
    logic              overrun;
    logic [29:0]       all_out;

    int errors = 0;
    int checks = 0;

    tdsp_ds_dma_wr_if #(.DATA_W(DATA_W), .HALF_AW(HALF_AW)) bus ();

    tdsp_ds_dma_wr #(.DATA_W(DATA_W), .HALF_AW(HALF_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .dma_enable   (dma_enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .clr_overrun  (clr_overrun),
        .half_done    (half_done),
        .overrun      (overrun),
        .bus          (bus)
    );

    assign bus.bus_grant = grant;
    assign all_out = {bus.bus_request, bus.as, bus.write, bus.address,
                      bus.data_out, bus.top_buf_flag, half_done, overrun};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    // Model: n-th write since reset lands at word n of the 256-word ping-pong buffer.
    function automatic logic [7:0] exp_addr(int n);
        return 8'(n % 256);
    endfunction

    function automatic logic exp_flag(int n);
        return ((n / 128) % 2) == 1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0; sample_valid = 1'b0; clr_overrun = 1'b0; grant = 1'b0; dma_enable = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 4; k++) begin
            do_reset();
            grant = 1'b1;
            sample_valid = 1'b1; sample_data = 16'($urandom);
            step(); sample_valid = 1'b0;
            repeat (4) step();
            grant = (k >= 2);
            if (k > 0) begin
                sample_valid = 1'b1; sample_data = 16'hBEEF;
                step();
                sample_valid = (k == 1);
                step();
                sample_valid = 1'b0;
                if (k == 3) step();
            end
            if (k == 1) begin
                checks++;
                if (overrun !== 1'b1) begin
                    errors++; $display("FAIL rst_pre_overrun: got %b expected 1", overrun);
                end
            end
            if (k == 2) begin
                checks++;
                if (bus.as !== 1'b1) begin
                    errors++; $display("FAIL rst_pre_xfer: as got %b expected 1", bus.as);
                end
            end
            reset = 1'b0;
            step(); step();
            checks++;
            if (all_out !== '0) begin
                errors++; $display("FAIL rst_outputs k=%0d: got %h expected 0", k, all_out);
            end
            reset = 1'b1; grant = 1'b1;
            step();
            checks++;
            if (all_out !== '0) begin
                errors++; $display("FAIL rst_idle k=%0d: got %h expected 0", k, all_out);
            end
            sample_valid = 1'b1; sample_data = 16'hA000 + 16'(k);
            step(); sample_valid = 1'b0;
            step();
            checks++;
            if ({bus.as, bus.write, bus.address, bus.data_out} !== {1'b1, 1'b1, 8'h00, 16'hA000 + 16'(k)}) begin
                errors++;
                $display("FAIL rst_first_write k=%0d: got as=%b addr=%h data=%h expected as=1 addr=00 data=%h",
                         k, bus.as, bus.address, bus.data_out, 16'hA000 + 16'(k));
            end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        grant = 1'b1;
        repeat (3) step();
        sample_valid = 1'b1; sample_data = 16'h1234;
        step(); sample_valid = 1'b0;
        checks++;
        if (bus.bus_request !== 1'b1 || bus.as !== 1'b0) begin
            errors++; $display("FAIL single_req: got req=%b as=%b expected req=1 as=0", bus.bus_request, bus.as);
        end
        step();
        checks++;
        if ({bus.bus_request, bus.as, bus.write, bus.address, bus.data_out} !== {3'b111, 8'h00, 16'h1234}) begin
            errors++;
            $display("FAIL single_xfer: got req=%b as=%b wr=%b addr=%h data=%h expected 1 1 1 00 1234",
                     bus.bus_request, bus.as, bus.write, bus.address, bus.data_out);
        end
        step();
        checks++;
        if ({bus.bus_request, bus.as, bus.write, bus.address, bus.data_out} !== '0) begin
            errors++;
            $display("FAIL single_release: got req=%b as=%b addr=%h data=%h expected all 0",
                     bus.bus_request, bus.as, bus.address, bus.data_out);
        end
    endtask

    task automatic test_delayed_grant();
        do_reset();
        grant = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h5A5A;
        step(); sample_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (bus.bus_request !== 1'b1 || bus.as !== 1'b0) begin
                errors++; $display("FAIL dgrant_wait c%0d: got req=%b as=%b expected req=1 as=0", i, bus.bus_request, bus.as);
            end
            if (i < 5) step();
        end
        grant = 1'b1;
        step();
        checks++;
        if ({bus.as, bus.write, bus.address, bus.data_out} !== {2'b11, 8'h00, 16'h5A5A}) begin
            errors++; $display("FAIL dgrant_xfer: got as=%b addr=%h data=%h expected as=1 addr=00 data=5a5a",
                               bus.as, bus.address, bus.data_out);
        end
        step();
        checks++;
        if (bus.as !== 1'b0 || bus.bus_request !== 1'b0) begin
            errors++; $display("FAIL dgrant_release: got as=%b req=%b expected 0 0", bus.as, bus.bus_request);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        grant = 1'b1;
        sample_valid = 1'b1; sample_data = 16'hAAAA;
        step(); sample_valid = 1'b0;
        step();
        checks++;
        if ({bus.as, bus.address, bus.data_out} !== {1'b1, 8'h00, 16'hAAAA}) begin
            errors++; $display("FAIL b2b_first: got as=%b addr=%h data=%h expected 1 00 aaaa", bus.as, bus.address, bus.data_out);
        end
        sample_valid = 1'b1; sample_data = 16'hBBBB;
        step(); sample_valid = 1'b0;
        repeat (2) step();
        checks++;
        if (bus.bus_request !== 1'b1) begin
            errors++; $display("FAIL b2b_req: got req=%b expected 1", bus.bus_request);
        end
        step();
        checks++;
        if ({bus.as, bus.address, bus.data_out} !== {1'b1, 8'h01, 16'hBBBB}) begin
            errors++; $display("FAIL b2b_xfer_capture: got as=%b addr=%h data=%h expected 1 01 bbbb", bus.as, bus.address, bus.data_out);
        end
        step();
        sample_valid = 1'b1; sample_data = 16'hCCCC;
        step(); sample_valid = 1'b0;
        repeat (2) step();
        checks++;
        if ({bus.as, bus.address, bus.data_out, overrun} !== {1'b1, 8'h02, 16'hCCCC, 1'b0}) begin
            errors++; $display("FAIL b2b_release_capture: got as=%b addr=%h data=%h ovr=%b expected 1 02 cccc 0",
                               bus.as, bus.address, bus.data_out, overrun);
        end
    endtask

    task automatic test_overrun();
        int nas;
        logic [DATA_W-1:0] got_d;
        logic [7:0] got_a;
        nas = 0; got_d = '0; got_a = '0;
        do_reset();
        grant = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h1111;
        step();
        sample_data = 16'h2222;
        step(); sample_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_set: got %b expected 1", overrun);
        end
        repeat (3) step();
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun);
        end
        sample_valid = 1'b1; sample_data = 16'h3333; clr_overrun = 1'b1;
        step(); sample_valid = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_set_beats_clr: got %b expected 1", overrun);
        end
        step();
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_clr: got %b expected 0", overrun);
        end
        clr_overrun = 1'b0; grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.as === 1'b1) begin
                nas++; got_d = bus.data_out; got_a = bus.address;
            end
        end
        checks++;
        if (nas != 1 || got_d !== 16'h1111 || got_a !== 8'h00) begin
            errors++; $display("FAIL ovr_only_first: got writes=%0d data=%h addr=%h expected 1 1111 00", nas, got_d, got_a);
        end
    endtask

    task automatic test_enable_drop();
        int nas;
        nas = 0;
        do_reset();
        grant = 1'b1;
        sample_valid = 1'b1; sample_data = 16'h0101;
        step(); sample_valid = 1'b0;
        repeat (4) step();
        grant = 1'b0;
        sample_valid = 1'b1; sample_data = 16'h0202;
        step(); sample_valid = 1'b0;
        dma_enable = 1'b0;
        step();
        checks++;
        if (bus.bus_request !== 1'b1) begin
            errors++; $display("FAIL en_req_hold: got req=%b expected 1", bus.bus_request);
        end
        sample_valid = 1'b1; sample_data = 16'h0303;
        step();
        grant = 1'b1;
        step();
        checks++;
        if ({bus.as, bus.address, bus.data_out} !== {1'b1, 8'h01, 16'h0202}) begin
            errors++; $display("FAIL en_complete: got as=%b addr=%h data=%h expected 1 01 0202", bus.as, bus.address, bus.data_out);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.as === 1'b1) nas++;
        end
        checks++;
        if (nas != 0 || overrun !== 1'b0) begin
            errors++; $display("FAIL en_ignored: got writes=%0d ovr=%b expected 0 0", nas, overrun);
        end
        sample_valid = 1'b0; dma_enable = 1'b1;
        step();
        sample_valid = 1'b1; sample_data = 16'h0404;
        step(); sample_valid = 1'b0;
        step();
        checks++;
        if ({bus.as, bus.address, bus.data_out} !== {1'b1, 8'h02, 16'h0404}) begin
            errors++; $display("FAIL en_count_held: got as=%b addr=%h data=%h expected 1 02 0404", bus.as, bus.address, bus.data_out);
        end
    endtask

    task automatic test_buffer_flip();
        int hd;
        logic [DATA_W-1:0] d;
        hd = 0;
        do_reset();
        grant = 1'b1;
        for (int i = 0; i < 256; i++) begin
            d = 16'($urandom);
            sample_valid = 1'b1; sample_data = d;
            step(); sample_valid = 1'b0;
            if (half_done === 1'b1) hd++;
            step();
            if (half_done === 1'b1) hd++;
            checks++;
            if ({bus.as, bus.address, bus.data_out} !== {1'b1, exp_addr(i), d}) begin
                errors++; $display("FAIL flip_write i=%0d: got as=%b addr=%h data=%h expected 1 %h %h",
                                   i, bus.as, bus.address, bus.data_out, exp_addr(i), d);
            end
            step();
            if (half_done === 1'b1) hd++;
            checks++;
            if (bus.top_buf_flag !== exp_flag(i + 1) || half_done !== ((i % 128) == 127)) begin
                errors++; $display("FAIL flip_flag i=%0d: got flag=%b hd=%b expected %b %b",
                                   i, bus.top_buf_flag, half_done, exp_flag(i + 1), (i % 128) == 127);
            end
            step();
            if (half_done === 1'b1) hd++;
        end
        checks++;
        if (hd != 2) begin
            errors++; $display("FAIL flip_pulses: got %0d expected 2", hd);
        end
    endtask

    task automatic test_random();
        int n;
        int bad;
        logic en;
        logic [DATA_W-1:0] d;
        n = 0;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            en = ($urandom_range(0, 3) != 0);
            d = 16'($urandom);
            grant = 1'b0;
            dma_enable = en; sample_valid = 1'b1; sample_data = d;
            step();
            sample_valid = 1'b0; dma_enable = 1'($urandom_range(0, 1));
            if (en) begin
                bad = 0;
                for (int w = 0; w < 20; w++) begin
                    grant = (w == 19) ? 1'b1 : 1'($urandom_range(0, 1));
                    step();
                    if (grant) break;
                    if (bus.as !== 1'b0 || bus.bus_request !== 1'b1) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++; $display("FAIL rnd_wait t=%0d: got %0d bad cycles expected 0", t, bad);
                end
                checks++;
                if ({bus.as, bus.write, bus.address, bus.data_out} !== {2'b11, exp_addr(n), d}) begin
                    errors++; $display("FAIL rnd_write t=%0d: got as=%b addr=%h data=%h expected 1 %h %h",
                                       t, bus.as, bus.address, bus.data_out, exp_addr(n), d);
                end
                n++;
                step();
                checks++;
                if (bus.bus_request !== 1'b0 || bus.as !== 1'b0) begin
                    errors++; $display("FAIL rnd_release t=%0d: got req=%b as=%b expected 0 0", t, bus.bus_request, bus.as);
                end
                step();
            end else begin
                checks++;
                if (bus.bus_request !== 1'b0) begin
                    errors++; $display("FAIL rnd_disabled t=%0d: got req=%b expected 0", t, bus.bus_request);
                end
            end
            repeat ($urandom_range(0, 2)) step();
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++; $display("FAIL rnd_overrun: got %b expected 0", overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_delayed_grant();
        test_back_to_back();
        test_overrun();
        test_enable_drop();
        test_buffer_flip();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tdsp_ds_dma_wr.md
# tdsp_ds_dma_wr

DMA writer that fills the TDSP data sample memory from an incoming sample stream. It holds one sample, requests the data bus, and on grant performs a single-cycle write strobe into the active half of the ping-pong sample buffer. It drives `top_buf_flag` and the `bus_request`/`as`/`write` handshake that the data bus decode logic steers and consumes. When a half fills it flips buffers and pulses a half-done indication to the TDSP.

## Interface
- DATA_W, 16, sample word width
- HALF_AW, 7, address bits per buffer half (half depth = 2^HALF_AW = 128 words)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- dma_enable  in  1  level; 1 = accept samples and transfer
- sample_valid  in  1  one-cycle strobe, sample_data valid
- sample_data  in  DATA_W  incoming sample
- bus_grant  in  1  grant from bus steering, sampled only in REQ
- clr_overrun  in  1  clears sticky overrun
- bus_request  out  1  request data bus
- as  out  1  address strobe, high exactly one cycle per write
- write  out  1  write strobe, identical to `as`
- address  out  HALF_AW+1  {top_buf_flag, wr_count}
- data_out  out  DATA_W  held sample, valid while `as`
- top_buf_flag  out  1  half currently being written (0 lower, 1 upper)
- half_done  out  1  one-cycle pulse after last word of a half is written
- overrun  out  1  sticky, sample lost

## Operation
- Holding register: one entry (hold_data, hold_valid). Sample captured when sample_valid & dma_enable & ~hold_valid. If sample_valid & dma_enable & hold_valid: sample dropped, overrun <= 1. sample_valid while dma_enable = 0: ignored, no overrun.
- overrun: set wins over clr_overrun in the same cycle.
- FSM states IDLE, REQ, XFER, RELEASE:
  - IDLE: bus_request = 0. hold_valid -> REQ.
  - REQ: bus_request = 1. bus_grant = 1 -> XFER, else stay (no timeout).
  - XFER: bus_request = 1, as = write = 1, address = {top_buf_flag, wr_count}, data_out = hold_data. Clear hold_valid, increment wr_count -> RELEASE.
  - RELEASE: bus_request = 0, as = write = 0 for one cycle -> IDLE.
- wr_count: HALF_AW bits, wraps 2^HALF_AW-1 -> 0. On the XFER with wr_count = all-ones: toggle top_buf_flag and assert half_done in the following cycle.
- dma_enable deasserted mid-transfer: the current sample completes through RELEASE. No new capture. wr_count and top_buf_flag hold their values.
- A new sample may be captured in the XFER cycle itself, because hold_valid clears that cycle. It is not captured in REQ.
- as/write are never high outside XFER. address/data_out are 0 outside XFER.
- Reset (reset = 0 at a clk edge, any state, including mid-XFER): state = IDLE, hold_valid = 0, wr_count = 0, top_buf_flag = 0, overrun = 0, and all outputs = 0 the following cycle. An in-flight write is abandoned, not completed.

## Timing
- Sample accepted at edge N -> bus_request high from cycle N+1.
- bus_grant sampled high at edge G (in REQ) -> as/write high for cycle G+1 only. RELEASE is cycle G+2. IDLE is cycle G+3.
- Minimum sample interval without overrun: 4 cycles with grant held high (capture, REQ, XFER, RELEASE). A sample arriving in the XFER cycle is accepted.
- half_done: high for the cycle after the wrapping XFER. top_buf_flag changes at the same edge.
- Outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset: hold reset = 0 for 2 cycles in every FSM state -> all outputs 0, next sample written to address 0x00.
- Single write: grant tied 1, sample 0x1234 at cycle 10 -> bus_request high cycle 11, as/write/address 0x00/data 0x1234 at cycle 12, request low cycle 13.
- Delayed grant: grant held 0 for 5 cycles in REQ -> bus_request stays 1, no as. Grant = 1 -> as exactly one cycle later, for one cycle.
- Buffer flip: 128 samples every 4 cycles -> addresses 0x00..0x7F, then top_buf_flag = 1 with one half_done pulse, next address 0x80. After 256 samples -> flag back to 0, address 0x00, two half_done pulses total.
- Overrun: grant 0, two samples 1 cycle apart -> first held, second dropped, overrun = 1. It persists until clr_overrun. set + clr same cycle -> stays 1. After grant, only the first sample is written.
- Enable drop: dma_enable = 0 during REQ -> transfer completes. Further samples ignored, overrun stays 0, wr_count unchanged.
